// File: rtl/keypad_bcd_reader.sv
// 4x4 keypad scanner/debouncer assembling decimal presses into packed BCD; `KEYPAD_IRQ_EN adds Key_IRQ.
// Latency: key accepted DEBOUNCE_SCANS frames after press; register effects one cycle after accept.
// Backpressure: none; Key_Ready is sticky until Keypad_RE, and a new '#' overwrites Keypad_Data.
module keypad_bcd_reader #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  Col_Sense,
   input  logic        Keypad_RE,
   input  logic        Keypad_Clear,
   output logic [3:0]  Row_Control,
   output logic [31:0] Entry_Data,
   output logic [31:0] Keypad_Data,
   output logic        Key_Ready,
   output logic [3:0]  Key_Code,
   output logic [3:0]  Digit_Count
`ifdef KEYPAD_IRQ_EN
   ,
   output logic        Key_IRQ
`endif
);

   localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [3:0]    DB_N      = 4'(DEBOUNCE_SCANS);
   localparam logic [3:0]    KEY_STAR  = 4'hE;
   localparam logic [3:0]    KEY_HASH  = 4'hF;

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

   logic [3:0]    col_s1, col_s2;
   logic [CW-1:0] scan_cnt;
   logic [1:0]    row_idx;
   logic [15:0]   frame;
   logic          frame_vld;

   state_t     state, state_nx;
   logic [3:0] db_cnt, db_cnt_nx, cnt_inc;
   logic [3:0] cand, cand_nx;
   logic       accept, accept_nx;

   logic [3:0] res_key;
   logic       res_none;
   logic [4:0] n_low;

   function automatic logic [3:0] key_map(input logic [3:0] idx);
      case (idx)
         4'd0:  key_map = 4'h1;
         4'd1:  key_map = 4'h2;
         4'd2:  key_map = 4'h3;
         4'd3:  key_map = 4'hA;
         4'd4:  key_map = 4'h4;
         4'd5:  key_map = 4'h5;
         4'd6:  key_map = 4'h6;
         4'd7:  key_map = 4'hB;
         4'd8:  key_map = 4'h7;
         4'd9:  key_map = 4'h8;
         4'd10: key_map = 4'h9;
         4'd11: key_map = 4'hC;
         4'd12: key_map = 4'hE;
         4'd13: key_map = 4'h0;
         4'd14: key_map = 4'hF;
         default: key_map = 4'hD;
      endcase
   endfunction

   assign Row_Control = ~(4'b0001 << row_idx);

   // Columns are sampled in the last cycle of each row period, long after the synchronizer settles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_s1    <= 4'hF;
         col_s2    <= 4'hF;
         scan_cnt  <= '0;
         row_idx   <= 2'd0;
         frame     <= 16'hFFFF;
         frame_vld <= 1'b0;
      end else begin
         col_s1    <= Col_Sense;
         col_s2    <= col_s1;
         frame_vld <= 1'b0;
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt                  <= '0;
            row_idx                   <= row_idx + 2'd1;
            frame[{row_idx, 2'b00} +: 4] <= col_s2;
            frame_vld                 <= (row_idx == 2'd3);
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      n_low   = 5'd0;
      res_key = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (!frame[i]) begin
            n_low   = n_low + 5'd1;
            res_key = key_map(4'(i));
         end
      end
      res_none = (n_low != 5'd1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         db_cnt <= 4'd0;
         cand   <= 4'd0;
         accept <= 1'b0;
      end else begin
         state  <= state_nx;
         db_cnt <= db_cnt_nx;
         cand   <= cand_nx;
         accept <= accept_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      db_cnt_nx = db_cnt;
      cand_nx   = cand;
      accept_nx = 1'b0;
      cnt_inc   = (db_cnt >= DB_N) ? DB_N : db_cnt + 4'd1;
      if (frame_vld) begin
         case (state)
            IDLE: if (!res_none) begin
               cand_nx   = res_key;
               db_cnt_nx = 4'd1;
               if (DB_N <= 4'd1) begin
                  accept_nx = 1'b1;
                  state_nx  = HELD;
               end else begin
                  state_nx = PRESS_DB;
               end
            end
            PRESS_DB: if (!res_none && res_key == cand) begin
               db_cnt_nx = cnt_inc;
               if (cnt_inc >= DB_N) begin
                  accept_nx = 1'b1;
                  state_nx  = HELD;
               end
            end else begin
               state_nx = IDLE;
            end
            HELD: if (res_none) begin
               db_cnt_nx = 4'd1;
               state_nx  = (DB_N <= 4'd1) ? IDLE : REL_DB;
            end
            REL_DB: if (res_none) begin
               db_cnt_nx = cnt_inc;
               if (cnt_inc >= DB_N) state_nx = IDLE;
            end else begin
               state_nx = HELD;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // cand stays stable in HELD, so it names the accepted key during the accept cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         Entry_Data  <= 32'h0;
         Keypad_Data <= 32'h0;
         Key_Ready   <= 1'b0;
         Key_Code    <= 4'h0;
         Digit_Count <= 4'd0;
      end else begin
         if (accept) Key_Code <= cand;
         if (accept && cand == KEY_HASH) Key_Ready <= 1'b1;
         else if (Keypad_RE)             Key_Ready <= 1'b0;
         if (accept && cand == KEY_HASH) begin
            Keypad_Data <= Entry_Data;
            Entry_Data  <= 32'h0;
            Digit_Count <= 4'd0;
         end else if (Keypad_Clear) begin
            Entry_Data  <= 32'h0;
            Digit_Count <= 4'd0;
         end else if (accept && cand <= 4'd9 && Digit_Count < 4'd8) begin
            Entry_Data  <= {Entry_Data[27:0], cand};
            Digit_Count <= Digit_Count + 4'd1;
         end else if (accept && cand == KEY_STAR && Digit_Count != 4'd0) begin
            Entry_Data  <= {4'h0, Entry_Data[31:4]};
            Digit_Count <= Digit_Count - 4'd1;
         end
      end
   end

`ifdef KEYPAD_IRQ_EN
   always_ff @(posedge clk) begin
      if (!rst) Key_IRQ <= 1'b0;
      else      Key_IRQ <= accept;
   end
`endif

endmodule

// File: tb/tb_keypad_bcd_reader.sv
// Directed bench for keypad_bcd_reader with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames).
module tb_keypad_bcd_reader;

   logic        clk;
   logic        rst_n;
   logic [3:0]  col_sense;
   logic        rea;
   logic        kclr;
   logic [3:0]  row_ctl;
   logic [31:0] entry;
   logic [31:0] kdata;
   logic        ready;
   logic [3:0]  code;
   logic [3:0]  cnt;
`ifdef KEYPAD_IRQ_EN
   logic        irq;
`endif

   logic [15:0] pressed;
   int          n_tests;
   int          n_fail;

   keypad_bcd_reader #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .clk          (clk),
      .rst          (rst_n),
      .Col_Sense    (col_sense),
      .Keypad_RE    (rea),
      .Keypad_Clear (kclr),
      .Row_Control  (row_ctl),
      .Entry_Data   (entry),
      .Keypad_Data  (kdata),
      .Key_Ready    (ready),
      .Key_Code     (code),
      .Digit_Count  (cnt)
`ifdef KEYPAD_IRQ_EN
      ,
      .Key_IRQ      (irq)
`endif
   );

   always #5 clk = ~clk;

   // Keypad matrix model: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_sense = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!row_ctl[r]) col_sense = ~pressed[r*4 +: 4];
   end

   typedef struct {
      int          act;     // 0 press key, 1 pulse RE, 2 pulse clear
      logic [3:0]  key;
      logic [31:0] e_entry;
      logic [3:0]  e_cnt;
      logic [3:0]  e_code;
      logic        e_ready;
      logic [31:0] e_kdata;
   } vec_t;

   vec_t vecs [20];

   function automatic int key_bit(input logic [3:0] k);
      case (k)
         4'h1: key_bit = 0;   4'h2: key_bit = 1;   4'h3: key_bit = 2;   4'hA: key_bit = 3;
         4'h4: key_bit = 4;   4'h5: key_bit = 5;   4'h6: key_bit = 6;   4'hB: key_bit = 7;
         4'h7: key_bit = 8;   4'h8: key_bit = 9;   4'h9: key_bit = 10;  4'hC: key_bit = 11;
         4'hE: key_bit = 12;  4'h0: key_bit = 13;  4'hF: key_bit = 14;  default: key_bit = 15;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k, input int cycles);
      pressed = 16'h0;
      pressed[key_bit(k)] = 1'b1;
      tick(cycles);
      pressed = 16'h0;
      tick(56);
   endtask

   task automatic pulse_re();
      rea = 1'b1; tick(1); rea = 1'b0; tick(2);
   endtask

   task automatic pulse_clr();
      kclr = 1'b1; tick(1); kclr = 1'b0; tick(2);
   endtask

   initial begin
      bit seen;
      clk = 1'b0; rst_n = 1'b0; pressed = 16'h0; rea = 1'b0; kclr = 1'b0;
      n_tests = 0; n_fail = 0;

      vecs[0]  = '{0, 4'h5, 32'h5,   4'd1, 4'h5, 1'b0, 32'h0};
      vecs[1]  = '{0, 4'h7, 32'h57,  4'd2, 4'h7, 1'b0, 32'h0};
      vecs[2]  = '{0, 4'hA, 32'h57,  4'd2, 4'hA, 1'b0, 32'h0};
      vecs[3]  = '{0, 4'hE, 32'h5,   4'd1, 4'hE, 1'b0, 32'h0};
      vecs[4]  = '{0, 4'hE, 32'h0,   4'd0, 4'hE, 1'b0, 32'h0};
      vecs[5]  = '{0, 4'hE, 32'h0,   4'd0, 4'hE, 1'b0, 32'h0};
      vecs[6]  = '{0, 4'h1, 32'h1,   4'd1, 4'h1, 1'b0, 32'h0};
      vecs[7]  = '{0, 4'h2, 32'h12,  4'd2, 4'h2, 1'b0, 32'h0};
      vecs[8]  = '{0, 4'h3, 32'h123, 4'd3, 4'h3, 1'b0, 32'h0};
      vecs[9]  = '{0, 4'hF, 32'h0,   4'd0, 4'hF, 1'b1, 32'h123};
      vecs[10] = '{1, 4'h0, 32'h0,   4'd0, 4'hF, 1'b0, 32'h123};
      vecs[11] = '{0, 4'hF, 32'h0,   4'd0, 4'hF, 1'b1, 32'h0};
      vecs[12] = '{0, 4'h9, 32'h9,   4'd1, 4'h9, 1'b1, 32'h0};
      vecs[13] = '{0, 4'hF, 32'h0,   4'd0, 4'hF, 1'b1, 32'h9};
      vecs[14] = '{0, 4'h6, 32'h6,   4'd1, 4'h6, 1'b1, 32'h9};
      vecs[15] = '{2, 4'h0, 32'h0,   4'd0, 4'h6, 1'b1, 32'h9};
      vecs[16] = '{1, 4'h0, 32'h0,   4'd0, 4'h6, 1'b0, 32'h9};
      vecs[17] = '{0, 4'h0, 32'h0,   4'd1, 4'h0, 1'b0, 32'h9};
      vecs[18] = '{0, 4'hD, 32'h0,   4'd1, 4'hD, 1'b0, 32'h9};
      vecs[19] = '{2, 4'h0, 32'h0,   4'd0, 4'hD, 1'b0, 32'h9};

      // Reset state and row scan order
      tick(3);
      chk("rst row",   {28'h0, row_ctl}, 32'hE);
      chk("rst entry", entry, 32'h0);
      chk("rst kdata", kdata, 32'h0);
      chk("rst ready", {31'h0, ready}, 32'h0);
      chk("rst code",  {28'h0, code}, 32'h0);
      chk("rst cnt",   {28'h0, cnt}, 32'h0);
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         logic [3:0] er;
         tick(1);
         er = ~(4'b0001 << ((i / 4) % 4));
         chk($sformatf("scan row c%0d", i), {28'h0, row_ctl}, {28'h0, er});
      end
      tick(40);
      chk("idle cnt",  {28'h0, cnt}, 32'h0);
      chk("idle code", {28'h0, code}, 32'h0);

      for (int i = 0; i < 20; i++) begin
         case (vecs[i].act)
            0:       press(vecs[i].key, 48);
            1:       pulse_re();
            default: pulse_clr();
         endcase
         chk($sformatf("v%0d entry", i), entry, vecs[i].e_entry);
         chk($sformatf("v%0d cnt", i),   {28'h0, cnt}, {28'h0, vecs[i].e_cnt});
         chk($sformatf("v%0d code", i),  {28'h0, code}, {28'h0, vecs[i].e_code});
         chk($sformatf("v%0d ready", i), {31'h0, ready}, {31'h0, vecs[i].e_ready});
         chk($sformatf("v%0d kdata", i), kdata, vecs[i].e_kdata);
      end

      // RE held through a '#' accept: set must win on the accept edge
      press(4'h2, 48);
      rea = 1'b1;
      pressed = 16'h0;
      pressed[key_bit(4'hF)] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tick(1);
         if (code == 4'hF) seen = 1'b1;
      end
      chk("re+hash seen", {31'h0, seen}, 32'h1);
      chk("re+hash ready", {31'h0, ready}, 32'h1);
      chk("re+hash kdata", kdata, 32'h2);
      rea = 1'b0;
      pressed = 16'h0;
      tick(56);
      chk("re+hash ready after", {31'h0, ready}, 32'h1);
      chk("re+hash entry", entry, 32'h0);

      // Bouncing '9': present on alternate frames only
      for (int t = 0; t < 6; t++) begin
         pressed = 16'h0;
         pressed[key_bit(4'h9)] = 1'b1;
         tick(16);
         pressed = 16'h0;
         tick(16);
      end
      tick(56);
      chk("bounce cnt",  {28'h0, cnt}, 32'h0);
      chk("bounce code", {28'h0, code}, 32'hF);

      // Ghosting: '1' and '2' together
      pressed = 16'h0;
      pressed[key_bit(4'h1)] = 1'b1;
      pressed[key_bit(4'h2)] = 1'b1;
      tick(64);
      pressed = 16'h0;
      tick(56);
      chk("ghost cnt",  {28'h0, cnt}, 32'h0);
      chk("ghost code", {28'h0, code}, 32'hF);

      // Long hold: single accept
      press(4'h4, 160);
      chk("hold cnt",   {28'h0, cnt}, 32'h1);
      chk("hold entry", entry, 32'h4);
      chk("hold code",  {28'h0, code}, 32'h4);
      pulse_clr();

      // Nine digits saturate at eight, then backspace and clear
      for (int d = 1; d <= 9; d++) press(4'(d), 48);
      chk("full entry", entry, 32'h12345678);
      chk("full cnt",   {28'h0, cnt}, 32'h8);
      chk("full code",  {28'h0, code}, 32'h9);
      press(4'hE, 48);
      chk("bksp entry", entry, 32'h01234567);
      chk("bksp cnt",   {28'h0, cnt}, 32'h7);
      pulse_clr();
      chk("clr entry", entry, 32'h0);
      chk("clr cnt",   {28'h0, cnt}, 32'h0);
      chk("clr ready", {31'h0, ready}, 32'h1);
      chk("clr kdata", kdata, 32'h2);

      // Clear held across a digit accept: clear wins, Key_Code still updates
      press(4'h5, 48);
      kclr = 1'b1;
      press(4'h8, 48);
      kclr = 1'b0;
      tick(2);
      chk("clr+dig entry", entry, 32'h0);
      chk("clr+dig cnt",   {28'h0, cnt}, 32'h0);
      chk("clr+dig code",  {28'h0, code}, 32'h8);

      // Reset after one frame of '3' held
      press(4'h1, 48);
      pressed = 16'h0;
      pressed[key_bit(4'h3)] = 1'b1;
      tick(16);
      rst_n = 1'b0;
      tick(3);
      chk("mrst entry", entry, 32'h0);
      chk("mrst kdata", kdata, 32'h0);
      chk("mrst ready", {31'h0, ready}, 32'h0);
      rst_n = 1'b1;
      pressed = 16'h0;
      tick(56);
      chk("mrst cnt",  {28'h0, cnt}, 32'h0);
      chk("mrst code", {28'h0, code}, 32'h0);
      press(4'h3, 16);
      chk("mrst short cnt", {28'h0, cnt}, 32'h0);
      press(4'h3, 48);
      chk("mrst full entry", entry, 32'h3);
      chk("mrst full code",  {28'h0, code}, 32'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_bcd_reader.md
Name: keypad_bcd_reader

Overview:
- Input-side counterpart of the 7-segment display path: scans a 4x4 matrix keypad, debounces it, and assembles decimal key presses into a 32-bit packed-BCD word for the processor.
- Row strobing mirrors the display's anode multiplexing.
- The entry in progress is exported for echo on the display. A completed entry is latched and flagged to the processor with a ready/read handshake.

Parameters:
- SCAN_DIV, 50000: clk cycles each row is driven; must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-keypad frames needed to accept a press or a release; range 1–15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- Col_Sense  in  4  keypad columns; active-low with external pull-ups; asynchronous to clk.
- Keypad_RE  in  1  processor read strobe; clears Key_Ready.
- Keypad_Clear  in  1  discards the entry in progress.
- Row_Control  out  4  row drive; one-hot active-low (exactly one bit 0).
- Entry_Data  out  32  entry in progress, packed BCD; newest digit in [3:0].
- Keypad_Data  out  32  last completed entry, packed BCD.
- Key_Ready  out  1  sticky flag: new Keypad_Data is available.
- Key_Code  out  4  code of the last accepted key.
- Digit_Count  out  4  digits in the entry (0–8).

Behaviour:
- Reset (rst=0 at a clk edge):
  - Row_Control=4'b1110 (row 0).
  - All counters, Entry_Data, Keypad_Data, Key_Ready, Key_Code, Digit_Count = 0.
  - FSM = IDLE.
  - Reset mid-scan or mid-debounce aborts immediately; no key event is produced.
- Synchronizer: Col_Sense passes through 2 flops before any use.
- Scan timing:
  - Row index r advances every SCAN_DIV cycles, wrapping 3→0.
  - In the last cycle of row r's period, synchronized columns are sampled into frame bits.
  - One frame = 4*SCAN_DIV cycles. The frame is evaluated in the cycle after the row-3 sample.
- Key map (row,col → code):
  - r0: 1,2,3,A(10)
  - r1: 4,5,6,B(11)
  - r2: 7,8,9,C(12)
  - r3: *(14),0,#(15),D(13)
- Frame result:
  - Exactly one low bit → that key.
  - Zero low bits → NONE.
  - Two or more low bits → NONE (ghosting rejected).
- FSM:
  - IDLE: result is a key K → PRESS_DB, cnt=1, cand=K.
  - PRESS_DB, result==cand:
    - cnt++.
    - When cnt reaches DEBOUNCE_SCANS → accept cand, go to HELD.
  - PRESS_DB, result differs → IDLE.
  - HELD: result==NONE → REL_DB, cnt=1. Any other result stays in HELD; no repeat.
  - REL_DB, result NONE:
    - cnt++.
    - When cnt reaches DEBOUNCE_SCANS → IDLE.
  - REL_DB, result not NONE → HELD.
  - With DEBOUNCE_SCANS=1, the accept happens on the first frame; the FSM passes directly IDLE→HELD.
- Accept event: one-cycle internal pulse. All register effects below occur at the clock edge following the pulse. Key_Code is set on every accept.
- Accept effects by key:
  - Digit d, Digit_Count<8: Entry_Data ← {Entry_Data[27:0],d}; Digit_Count++.
  - Digit d, Digit_Count==8: digit ignored; Entry_Data unchanged.
  - '*' (backspace), Digit_Count>0: Entry_Data ← {4'h0,Entry_Data[31:4]}; Digit_Count--.
  - '*', Digit_Count==0: no change.
  - '#' (enter): Keypad_Data ← Entry_Data; Key_Ready ← 1; Entry_Data ← 0; Digit_Count ← 0. An empty entry is allowed and latches 0.
  - A–D: only Key_Code is updated.
- Handshake:
  - Keypad_RE=1 clears Key_Ready on the next edge.
  - Same cycle as a '#' accept: set wins, Key_Ready stays 1.
  - A second '#' while Key_Ready=1 overwrites Keypad_Data (no queue).
- Keypad_Clear:
  - Zeroes Entry_Data and Digit_Count.
  - Does not touch Keypad_Data or Key_Ready.
  - If coincident with a digit/'*' accept, clear wins.
  - If coincident with a '#' accept, the '#' latch still takes the pre-clear Entry_Data.
- Counters:
  - Scan counter width ≥ clog2(SCAN_DIV).
  - Debounce counter 4 bits, saturating at DEBOUNCE_SCANS.

Optional Feature:
- Macro: KEYPAD_IRQ_EN.
- Defined:
  - Adds output port Key_IRQ (1 bit, reset 0).
  - Key_IRQ pulses high for exactly one cycle, coincident with the Key_Code update, on every accepted key.
  - Key_IRQ pulses for ignored digits too.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame = 16 cycles.
- Reset/scan: hold rst=0 for 3 cycles, then release with Col_Sense=4'hF → Row_Control cycles 1110,1101,1011,0111, changing every 4 clk; all outputs 0; no accept.
- Digit entry: press key '5' for 3 frames, release, then repeat with '7' → Entry_Data=32'h00000057, Digit_Count=2, Key_Code=7, Key_Ready=0.
- Enter and handshake: after entering 1,2,3, press '#' → Keypad_Data=32'h00000123, Key_Ready=1, Entry_Data=0. Then pulse Keypad_RE → Key_Ready=0. Also drive RE in the same cycle as a '#' accept → Key_Ready=1.
- Bounce and ghosting:
  - Toggle '9' on and off each frame → no accept.
  - Press '1' and '2' together for 4 frames → no accept.
  - Holding '4' for 10 frames → exactly one accept.
- Limits:
  - Enter 9 digits 1–9 → Entry_Data=32'h12345678, Digit_Count=8.
  - Then '*' → Entry_Data=32'h01234567, Digit_Count=7.
  - Then Keypad_Clear → Entry_Data=0, Digit_Count=0.
- Reset mid-debounce: assert rst after 1 frame of '3' held → no accept. After release, '3' must be debounced afresh.
